// File: rtl/step_sequencer_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : step_sequencer_core                                             |
// | Purpose  : Multi-track drum step sequencer with live pattern editing,      |
// |            tempo-divided playback and a RAW pad pass-through mode.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module step_sequencer_core #(
    parameter int NSTEPS  = 8,
    parameter int NTRACKS = 4,
    parameter int TEMPO_W = 8,
    parameter int IDX_W   = $clog2(NSTEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [TEMPO_W-1:0] tempo_lim,
    input  logic [IDX_W-1:0]   edit_idx,
    input  logic [NTRACKS-1:0] tgl,
    input  logic               tgl_strobe,
    input  logic               clear_strobe,
    input  logic [NTRACKS-1:0] raw_hits,
    output logic [IDX_W-1:0]   step_idx,
    output logic [NSTEPS-1:0]  step_onehot,
    output logic [NTRACKS-1:0] edit_row,
    output logic               tick,
    output logic [NTRACKS-1:0] trig
);

    localparam logic [1:0] c_MODE_EDIT = 2'd0;
    localparam logic [1:0] c_MODE_PLAY = 2'd1;
    localparam logic [1:0] c_MODE_RAW  = 2'd2;

    logic [NTRACKS-1:0] r_pattern [NSTEPS];
    logic [IDX_W-1:0]   r_step_idx;
    logic [NSTEPS-1:0]  r_onehot;
    logic [TEMPO_W-1:0] r_cnt;
    logic               r_tick;
    logic [NTRACKS-1:0] r_trig;
    logic [1:0]         r_prev_mode;
    logic [NTRACKS-1:0] r_raw_prev;

    logic               w_play;
    logic               w_raw;
    logic               w_entry;
    logic               w_adv;
    logic [IDX_W-1:0]   w_next_idx;

    assign w_play     = (mode == c_MODE_PLAY);
    assign w_raw      = (mode == c_MODE_RAW);
    assign w_entry    = w_play && (r_prev_mode != c_MODE_PLAY);
    // >= rather than == so a limit lowered below the running count ticks at once
    assign w_adv      = w_play && !w_entry && (r_cnt >= tempo_lim);
    assign w_next_idx = r_step_idx + IDX_W'(1);

    // Pattern storage: one row per step; clear beats toggle, RAW locks edits.
    generate
        for (genvar s = 0; s < NSTEPS; s++) begin : g_row
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pattern[s] <= '0;
                end else if (!w_raw) begin
                    if (clear_strobe) begin
                        r_pattern[s] <= '0;
                    end else if (tgl_strobe && (edit_idx == IDX_W'(s))) begin
                        r_pattern[s] <= r_pattern[s] ^ tgl;
                    end
                end
            end
        end
    endgenerate

    assign edit_row = r_pattern[edit_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_idx  <= '0;
            r_onehot    <= NSTEPS'(1);
            r_cnt       <= '0;
            r_tick      <= 1'b0;
            r_trig      <= '0;
            r_prev_mode <= c_MODE_EDIT;
            r_raw_prev  <= '0;
        end else begin
            r_prev_mode <= mode;
            r_raw_prev  <= raw_hits;
            r_tick      <= 1'b0;
            r_trig      <= '0;
            if (w_entry) begin
                r_step_idx <= '0;
                r_onehot   <= NSTEPS'(1);
                r_cnt      <= '0;
                r_tick     <= 1'b1;
                r_trig     <= r_pattern[0];
            end else if (w_adv) begin
                r_step_idx <= w_next_idx;
                r_onehot   <= {r_onehot[NSTEPS-2:0], r_onehot[NSTEPS-1]};
                r_cnt      <= '0;
                r_tick     <= 1'b1;
                r_trig     <= r_pattern[w_next_idx];
            end else if (w_play) begin
                r_cnt <= r_cnt + TEMPO_W'(1);
            end else begin
                r_cnt <= '0;
                // Pads held before entering RAW stay silent since r_raw_prev always tracks
                if (w_raw) begin
                    r_trig <= raw_hits & ~r_raw_prev;
                end
            end
        end
    end

    assign step_idx    = r_step_idx;
    assign step_onehot = r_onehot;
    assign tick        = r_tick;
    assign trig        = r_trig;

endmodule
`default_nettype wire

// File: doc/step_sequencer_core.md
Name: step_sequencer_core

Overview:
Parametrised multi-track step sequencer for the drum machine. It stores an NSTEPS x NTRACKS hit pattern and supports live editing. An internal tempo divider advances a step cursor, and the block emits one-cycle per-track trigger pulses to the sample players. It sits between the mode controller/keypad decode and the sample/PWM audio path. It also provides a RAW pass-through mode for live finger drumming.

Parameters:
NSTEPS, 8, number of steps per pattern; power of two, 2..32
NTRACKS, 4, number of tracks (samples); 1..8
TEMPO_W, 8, width of the tempo divider limit and counter
IDX_W, $clog2(NSTEPS), step index width (derived; do not override)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
mode  in  2  0=EDIT, 1=PLAY, 2=RAW, 3=reserved (behaves as EDIT)
tempo_lim  in  TEMPO_W  tick every tempo_lim+1 clocks in PLAY
edit_idx  in  IDX_W  step selected for editing
tgl  in  NTRACKS  track bits to toggle at edit_idx
tgl_strobe  in  1  one-cycle qualifier for tgl
clear_strobe  in  1  one-cycle request to clear the whole pattern
raw_hits  in  NTRACKS  live pads, level-sensitive, used in RAW
step_idx  out  IDX_W  current playback step
step_onehot  out  NSTEPS  1 << step_idx, for LED display
edit_row  out  NTRACKS  stored pattern at edit_idx (combinational read)
tick  out  1  one-cycle pulse on each step advance
trig  out  NTRACKS  one-cycle per-track trigger pulses

Behaviour:
- Single clock domain. Reset is asynchronous and active-high on all state.
- Reset values:
  - pattern all 0
  - step_idx 0, step_onehot = 1
  - tick 0, trig 0
  - tempo counter 0
  - prev_mode = EDIT, raw_prev 0
- Pattern edit:
  - In EDIT, PLAY and reserved mode: when tgl_strobe=1, pattern[edit_idx] <= pattern[edit_idx] ^ tgl on the next edge.
  - Edits are ignored in RAW.
  - clear_strobe zeroes the whole pattern in any mode except RAW. It has priority over a toggle in the same cycle.
- edit_row reflects pattern[edit_idx] combinationally; it shows the new value the cycle after the write edge.
- PLAY entry: when mode==PLAY and prev_mode!=PLAY, on the next edge:
  - step_idx <= 0, counter <= 0
  - tick <= 1, trig <= pattern[0]
  - The start step always fires immediately.
- PLAY running:
  - The counter increments each clock.
  - When counter >= tempo_lim (>= so that a lowered limit takes effect at once), on the next edge: counter <= 0, step_idx <= (step_idx+1) mod NSTEPS, tick <= 1, trig <= pattern[next step].
  - All other cycles: tick <= 0, trig <= 0.
  - tempo_lim=0 gives a tick every clock.
  - Wrap: step NSTEPS-1 advances to 0.
- Same-cycle edit and read: trig samples the pattern value before a write in the same cycle (old data).
- Leaving PLAY: the counter is held at 0 and step_idx holds its last value. tick and trig are 0 from the next edge onward; no trailing pulse.
- EDIT / reserved: trig=0, tick=0.
- RAW:
  - raw_prev <= raw_hits every clock, in every mode.
  - trig <= raw_hits & ~raw_prev, i.e. one-cycle rising-edge pulses with 1-cycle latency. Held pads do not retrigger.
  - On entry to RAW, pads already held do not fire, because raw_prev tracks in all modes.
- prev_mode <= mode every clock. A PLAY->EDIT->PLAY sequence restarts at step 0.
- Reset asserted mid-playback returns everything to reset values immediately (asynchronous). After release with mode==PLAY, the entry rule fires on the first edge.
- Widths: the counter is TEMPO_W bits, compared unsigned. step_idx wraps naturally only because NSTEPS is a power of two.

Test Plan:
1. Reset, EDIT, edit_idx=3, tgl=4'b0101 pulsed -> edit_row=0101 next cycle. Pulse again -> 0000. Pulse tgl with clear_strobe same cycle -> pattern all 0.
2. pattern[0]=0001, pattern[1]=0010, tempo_lim=3, mode->PLAY:
   - trig=0001 and tick the edge after entry.
   - Then trig=0010 exactly 4 clocks later, step_idx=1, step_onehot=8'h02.
3. Run PLAY through 8 ticks with tempo_lim=0 -> tick every cycle; step_idx 0..7 then wraps to 0 with trig=pattern[0].
4. tempo_lim 200->2 while counter=50 -> tick on the next cycle, then every 3 clocks. Toggle the step being triggered on the same cycle -> trig carries the old value.
5. RAW: hold raw_hits[2] high 5 cycles -> a single trig=0100 pulse one cycle after the rise. tgl_strobe in RAW -> pattern unchanged.
6. Assert rst mid-PLAY at step 5 -> step_idx=0, trig=0 immediately. Release with mode=PLAY -> start trig=pattern[0] on the first edge.
